flash_arbiter: RTL and testbench

Shares the single weight/bias flash port between two requesters: the network controller (weight/bias fetch) and the SPI host path (flash readback/debug). Arbitrates each access, drives the flash_ready strobe and flash_address, waits the fixed flash read latency, then returns the 16-bit word with a one-cycle valid pulse to the granted requester. A lock input lets the network controller issue back-to-back bias/weight reads without losing the port.

---
 rtl/flash_arb_pkg.sv | 16 +
 rtl/flex_counter.sv | 36 +++
 rtl/flash_arbiter.sv | 141 ++++++++++++++
 tb/tb_flash_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash port arbiter.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arbState_t;

    localparam logic OWNER_NET  = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

    localparam int DEFAULT_FLASH_LATENCY = 11;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear, count enable and programmable wrap value.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] count_next;

    always_comb begin
        count_next = count_out;
        if (clear) begin
            count_next = '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                count_next = NUM_CNT_BITS'(1);
            end else begin
                count_next = count_out + NUM_CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else begin
            count_out <= count_next;
        end
    end

endmodule

// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing the weight/bias flash read port between the
// network controller and the SPI host path, with a network lock for bursts.
module flash_arbiter
    import flash_arb_pkg::*;
#(
    parameter int FLASH_LATENCY = DEFAULT_FLASH_LATENCY,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              net_req,
    input  logic [ADDR_W-1:0] net_addr,
    input  logic              net_lock,
    output logic              net_gnt,
    output logic              net_valid,
    output logic [DATA_W-1:0] net_data,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic              host_valid,
    output logic [DATA_W-1:0] host_data,
    output logic              flash_ready,
    output logic [ADDR_W-1:0] flash_address,
    input  logic [DATA_W-1:0] flashData_out,
    output logic              busy
);

    // The counter reads 0 in the first WAIT cycle, so it holds LATENCY-1 in the last one.
    localparam logic [3:0] LAST_CNT = 4'(FLASH_LATENCY - 1);

    arbState_t state;
    arbState_t state_next;
    logic      owner;
    logic      last_grant;
    logic      grant_load;
    logic      grant_owner;
    logic      data_load;
    logic      cnt_clear;
    logic      cnt_enable;
    logic [3:0] wait_cnt;

    flex_counter #(
        .NUM_CNT_BITS(4)
    ) u_wait_cnt (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (cnt_clear),
        .count_enable(cnt_enable),
        .rollover_val(4'hF),
        .count_out   (wait_cnt)
    );

    always_comb begin
        state_next  = state;
        net_gnt     = 1'b0;
        host_gnt    = 1'b0;
        flash_ready = 1'b0;
        cnt_clear   = 1'b0;
        cnt_enable  = 1'b0;
        grant_load  = 1'b0;
        grant_owner = owner;
        data_load   = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester that was not served last wins.
                if (net_req && (!host_req || last_grant == OWNER_HOST)) begin
                    net_gnt     = 1'b1;
                    grant_load  = 1'b1;
                    grant_owner = OWNER_NET;
                    state_next  = ISSUE;
                end else if (host_req) begin
                    host_gnt    = 1'b1;
                    grant_load  = 1'b1;
                    grant_owner = OWNER_HOST;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                flash_ready = 1'b1;
                cnt_clear   = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                cnt_enable = 1'b1;
                if (wait_cnt == LAST_CNT) begin
                    data_load  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // A locked network owner keeps the port and skips IDLE.
                if (owner == OWNER_NET && net_lock && net_req) begin
                    net_gnt     = 1'b1;
                    grant_load  = 1'b1;
                    grant_owner = OWNER_NET;
                    state_next  = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            owner         <= OWNER_NET;
            last_grant    <= OWNER_HOST;
            flash_address <= '0;
        end else begin
            state <= state_next;
            if (grant_load) begin
                owner         <= grant_owner;
                flash_address <= (grant_owner == OWNER_NET) ? net_addr : host_addr;
            end
            if (state == DONE) begin
                last_grant <= owner;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            net_data  <= '0;
            host_data <= '0;
        end else if (data_load) begin
            if (owner == OWNER_NET) begin
                net_data <= flashData_out;
            end else begin
                host_data <= flashData_out;
            end
        end
    end

    assign net_valid  = (state == DONE) && (owner == OWNER_NET);
    assign host_valid = (state == DONE) && (owner == OWNER_HOST);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: requester agents, a flash latency model and event logs.
module tb_flash_arbiter;

    localparam int L = 11;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        net_req = 1'b0;
    logic [15:0] net_addr = 16'h0;
    logic        net_lock = 1'b0;
    logic        net_gnt;
    logic        net_valid;
    logic [15:0] net_data;
    logic        host_req = 1'b0;
    logic [15:0] host_addr = 16'h0;
    logic        host_gnt;
    logic        host_valid;
    logic [15:0] host_data;
    logic        flash_ready;
    logic [15:0] flash_address;
    logic [15:0] flashData_out;
    logic        busy;

    flash_arbiter dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .net_req      (net_req),
        .net_addr     (net_addr),
        .net_lock     (net_lock),
        .net_gnt      (net_gnt),
        .net_valid    (net_valid),
        .net_data     (net_data),
        .host_req     (host_req),
        .host_addr    (host_addr),
        .host_gnt     (host_gnt),
        .host_valid   (host_valid),
        .host_data    (host_data),
        .flash_ready  (flash_ready),
        .flash_address(flash_address),
        .flashData_out(flashData_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] flash_word(input logic [15:0] a);
        if (a == 16'h0040) return 16'hA5C3;
        return a ^ 16'h3C3C;
    endfunction

    // Flash: data valid only in the L-th cycle after the strobe cycle.
    int          fcnt = 0;
    logic [15:0] faddr = 16'h0;
    always @(negedge clk) begin
        if (!n_rst) fcnt <= 0;
        else if (flash_ready) begin
            fcnt  <= 1;
            faddr <= flash_address;
        end else if (fcnt != 0 && fcnt < 40) fcnt <= fcnt + 1;
    end
    assign flashData_out = (fcnt == L + 1) ? flash_word(faddr) : 16'hDEAD;

    int ng_cyc[$], hg_cyc[$], fr_cyc[$], fr_addr[$];
    int nv_cyc[$], nv_dat[$], hv_cyc[$], hv_dat[$];
    int both_v = 0;
    logic ng_seen = 1'b0;
    logic hg_seen = 1'b0;

    always @(negedge clk) begin
        ng_seen = net_gnt;
        hg_seen = host_gnt;
        if (net_gnt) ng_cyc.push_back(cyc);
        if (host_gnt) hg_cyc.push_back(cyc);
        if (flash_ready) begin
            fr_cyc.push_back(cyc);
            fr_addr.push_back(int'(flash_address));
        end
        if (net_valid) begin
            nv_cyc.push_back(cyc);
            nv_dat.push_back(int'(net_data));
        end
        if (host_valid) begin
            hv_cyc.push_back(cyc);
            hv_dat.push_back(int'(host_data));
        end
        if (net_valid && host_valid) both_v++;
    end

    logic [15:0] net_q[$];
    logic [15:0] host_q[$];

    // Each agent holds req with the queue head until it sees its grant.
    always @(posedge clk) begin
        #1;
        if (ng_seen && net_q.size() > 0) void'(net_q.pop_front());
        net_req  = (net_q.size() > 0);
        net_addr = (net_q.size() > 0) ? net_q[0] : 16'h0;
    end

    always @(posedge clk) begin
        #1;
        if (hg_seen && host_q.size() > 0) void'(host_q.pop_front());
        host_req  = (host_q.size() > 0);
        host_addr = (host_q.size() > 0) ? host_q[0] : 16'h0;
    end

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1000;
    endfunction

    task automatic clear_logs();
        ng_cyc.delete(); hg_cyc.delete(); fr_cyc.delete(); fr_addr.delete();
        nv_cyc.delete(); nv_dat.delete(); hv_cyc.delete(); hv_dat.delete();
    endtask

    task automatic wait_idle(input int max, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            @(negedge clk);
            if (!busy && !net_req && !host_req && net_q.size() == 0 && host_q.size() == 0)
                done = 1'b1;
        end
        check_val({tag, " idle"}, 32'(done), 32'd1);
    endtask

    int base;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst gnt",   {30'd0, net_gnt, host_gnt}, 32'd0);
        check_val("rst valid", {30'd0, net_valid, host_valid}, 32'd0);
        check_val("rst data",  {net_data, host_data}, 32'd0);
        check_val("rst flash", {15'd0, flash_ready, flash_address}, 32'd0);
        check_val("rst busy",  32'(busy), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Single network read
        clear_logs();
        net_q.push_back(16'h0040);
        base = cyc + 1;
        wait_idle(40, "t1");
        check_val("t1 ngnt cyc",  32'(qget(ng_cyc, 0) - base), 32'd0);
        check_val("t1 fr cyc",    32'(qget(fr_cyc, 0) - base), 32'd1);
        check_val("t1 fr addr",   32'(qget(fr_addr, 0)), 32'h0040);
        check_val("t1 nvld cyc",  32'(qget(nv_cyc, 0) - base), 32'd13);
        check_val("t1 nvld data", 32'(qget(nv_dat, 0)), 32'hA5C3);
        check_val("t1 nvld cnt",  32'(nv_cyc.size()), 32'd1);
        check_val("t1 host evts", 32'(hg_cyc.size() + hv_cyc.size()), 32'd0);
        check_val("t1 host data", 32'(host_data), 32'd0);
        check_val("t1 ndata hold", 32'(net_data), 32'hA5C3);

        // Simultaneous request right after reset: network first
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        clear_logs();
        net_q.push_back(16'h0010);
        host_q.push_back(16'h0800);
        base = cyc + 1;
        wait_idle(60, "t2");
        check_val("t2 ngnt cyc",  32'(qget(ng_cyc, 0) - base), 32'd0);
        check_val("t2 nvld cyc",  32'(qget(nv_cyc, 0) - base), 32'd13);
        check_val("t2 nvld data", 32'(qget(nv_dat, 0)), 32'h3C2C);
        check_val("t2 hgnt cyc",  32'(qget(hg_cyc, 0) - base), 32'd14);
        check_val("t2 hfr cyc",   32'(qget(fr_cyc, 1) - base), 32'd15);
        check_val("t2 hfr addr",  32'(qget(fr_addr, 1)), 32'h0800);
        check_val("t2 hvld cyc",  32'(qget(hv_cyc, 0) - base), 32'd27);
        check_val("t2 hvld data", 32'(qget(hv_dat, 0)), 32'h343C);

        // Round robin, no lock
        clear_logs();
        net_q.push_back(16'h0020); net_q.push_back(16'h0021);
        host_q.push_back(16'h0900); host_q.push_back(16'h0901);
        base = cyc + 1;
        wait_idle(100, "t3");
        check_val("t3 ngnt0", 32'(qget(ng_cyc, 0) - base), 32'd0);
        check_val("t3 hgnt0", 32'(qget(hg_cyc, 0) - base), 32'd14);
        check_val("t3 ngnt1", 32'(qget(ng_cyc, 1) - base), 32'd28);
        check_val("t3 hgnt1", 32'(qget(hg_cyc, 1) - base), 32'd42);
        check_val("t3 nvld1 data", 32'(qget(nv_dat, 1)), 32'h3C1D);
        check_val("t3 hvld1 cyc",  32'(qget(hv_cyc, 1) - base), 32'd55);
        check_val("t3 hvld1 data", 32'(qget(hv_dat, 1)), 32'h353D);

        // Locked network burst with host waiting
        clear_logs();
        net_lock = 1'b1;
        net_q.push_back(16'h0100); net_q.push_back(16'h0101); net_q.push_back(16'h0102);
        host_q.push_back(16'h0A00);
        base = cyc + 1;
        while (cyc < base + 30) @(negedge clk);
        net_lock = 1'b0;
        wait_idle(80, "t4");
        check_val("t4 ngnt1", 32'(qget(ng_cyc, 1) - base), 32'd13);
        check_val("t4 ngnt2", 32'(qget(ng_cyc, 2) - base), 32'd26);
        check_val("t4 fr1",   32'(qget(fr_cyc, 1) - base), 32'd14);
        check_val("t4 fr2 addr", 32'(qget(fr_addr, 2)), 32'h0102);
        check_val("t4 nvld0", 32'(qget(nv_cyc, 0) - base), 32'd13);
        check_val("t4 nvld1", 32'(qget(nv_cyc, 1) - base), 32'd26);
        check_val("t4 nvld2", 32'(qget(nv_cyc, 2) - base), 32'd39);
        check_val("t4 nvld1 data", 32'(qget(nv_dat, 1)), 32'h3D3D);
        check_val("t4 nvld2 data", 32'(qget(nv_dat, 2)), 32'h3D3E);
        check_val("t4 hgnt",  32'(qget(hg_cyc, 0) - base), 32'd40);
        check_val("t4 hvld data", 32'(qget(hv_dat, 0)), 32'h363C);

        // Host request withdrawn while network owns the port
        clear_logs();
        net_q.push_back(16'h0040);
        base = cyc + 1;
        while (cyc < base + 3) @(negedge clk);
        host_q.push_back(16'h0B00);
        while (cyc < base + 6) @(negedge clk);
        host_q.delete();
        wait_idle(40, "t5");
        check_val("t5 host gnt", 32'(hg_cyc.size()), 32'd0);
        check_val("t5 host vld", 32'(hv_cyc.size()), 32'd0);
        check_val("t5 nvld cyc", 32'(qget(nv_cyc, 0) - base), 32'd13);

        // Reset in the middle of WAIT
        clear_logs();
        net_q.push_back(16'h0050);
        base = cyc + 1;
        while (cyc < base + 6) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_val("t6 busy",   32'(busy), 32'd0);
        check_val("t6 fready", 32'(flash_ready), 32'd0);
        check_val("t6 ndata",  32'(net_data), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        check_val("t6 nvld cnt",   32'(nv_cyc.size()), 32'd0);
        check_val("t6 ngnt cnt",   32'(ng_cyc.size()), 32'd1);
        check_val("t6 busy after", 32'(busy), 32'd0);
        check_val("t6 ndata after", 32'(net_data), 32'd0);

        check_val("both valid", 32'(both_v), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
